dmem_responder: RTL and testbench

- Target side of the processor's data-memory port (address/data/wren/q). Replaces the bare syncram.
- Decodes each access to one of three regions: internal word RAM, MMIO registers, or unmapped.
- Feeds a small TX FIFO that software fills by storing to MMIO. The FIFO drains over a valid/ready stream toward an external consumer.

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder_tx_fifo.sv | 83 ++++++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register
// offsets, STATUS bit positions and the address-region decode.
package dmem_responder_pkg;

    // MMIO word offsets relative to MMIO_BASE
    localparam logic [11:0] OFF_CYCLES = 12'd0;
    localparam logic [11:0] OFF_LED    = 12'd1;
    localparam logic [11:0] OFF_TXDATA = 12'd2;
    localparam logic [11:0] OFF_STATUS = 12'd3;
    localparam logic [11:0] MMIO_SPAN  = 12'd4;

    // STATUS register layout
    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    // Classify a word address; anything outside RAM and the MMIO window is unmapped.
    function automatic region_e decode_region(logic [11:0] addr, int unsigned ram_depth,
                                              logic [11:0] mmio_base);
        if ({20'b0, addr} < ram_depth) begin
            return REG_RAM;
        end
        if ((addr >= mmio_base) && ((addr - mmio_base) < MMIO_SPAN)) begin
            return REG_MMIO;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory port plus TX byte stream, bundled as one interface.
interface dmem_responder_if;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Processor / stream-consumer side
    modport master (
        output address_dmem, data, wren, tx_ready,
        input  q_dmem, tx_data, tx_valid
    );

    // Responder side
    modport slave (
        input  address_dmem, data, wren, tx_ready,
        output q_dmem, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// First-word fall-through TX FIFO with sticky, write-1-to-clear overflow flag.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module dmem_responder_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    input  logic             ovf_clr,
    output logic             ovf
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop, ovf_set;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign dout  = mem_q[rptr_q];

    // Next-state: pointer/count updates and overflow set-wins-over-clear
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        ovf_set = push && full && !do_pop;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Control state; flush empties the FIFO and clears overflow
    always_ff @(posedge clock) begin
        if (flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: word RAM, MMIO registers (CYCLES, LED, TXDATA, STATUS)
// and a TX FIFO drained over a valid/ready byte stream.
// Optional macro DMEM_RESPONDER_TIMER_EN builds the free-running CYCLES counter;
// without it CYCLES reads as 0.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
    input  logic                    clock,
    input  logic                    reset,
    dmem_responder_if.slave         bus,
    output logic [31:0]             led_out
);
    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    region_e     region;
    logic [11:0] mmio_off;
    logic        mmio_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic        ram_we;
    logic [31:0] ram_mem [RAM_DEPTH];

    logic [31:0] q_dmem_q, q_dmem_d;
    logic [31:0] led_q, led_d;
    logic [31:0] cycles_val;
    logic [31:0] status;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf, ovf_clr;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    assign region   = decode_region(bus.address_dmem, RAM_DEPTH, MMIO_BASE);
    assign mmio_off = bus.address_dmem - MMIO_BASE;
    assign mmio_hit = (region == REG_MMIO);
    assign ram_idx  = bus.address_dmem[RAM_AW-1:0];
    assign ram_we   = bus.wren && (region == REG_RAM);

    assign fifo_push = bus.wren && mmio_hit && (mmio_off == OFF_TXDATA);
    assign fifo_pop  = bus.tx_valid && bus.tx_ready;
    assign ovf_clr   = bus.wren && mmio_hit && (mmio_off == OFF_STATUS)
                       && bus.data[STATUS_OVF_BIT];

    assign bus.q_dmem   = q_dmem_q;
    assign bus.tx_data  = fifo_dout;
    assign bus.tx_valid = !fifo_empty;
    assign led_out      = led_q;

`ifdef DMEM_RESPONDER_TIMER_EN
    logic [31:0] cycles_q, cycles_d;

    // Free-running counter, wraps naturally at 2^32
    always_comb begin
        cycles_d = cycles_q + 32'd1;
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_val = cycles_q;
`else
    assign cycles_val = '0;
`endif

    // STATUS snapshot of the FIFO before any same-cycle push or pop
    always_comb begin
        status                            = '0;
        status[STATUS_EMPTY_BIT]          = fifo_empty;
        status[STATUS_FULL_BIT]           = fifo_full;
        status[STATUS_OVF_BIT]            = fifo_ovf;
        status[STATUS_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    // Read mux and LED next-state; RAM read sees pre-write content
    always_comb begin
        q_dmem_d = '0;
        led_d    = led_q;
        case (region)
            REG_RAM: q_dmem_d = ram_mem[ram_idx];
            REG_MMIO: begin
                case (mmio_off)
                    OFF_CYCLES: q_dmem_d = cycles_val;
                    OFF_LED:    q_dmem_d = led_q;
                    OFF_STATUS: q_dmem_d = status;
                    default:    q_dmem_d = '0;
                endcase
            end
            default: q_dmem_d = '0;
        endcase
        if (bus.wren && mmio_hit && (mmio_off == OFF_LED)) begin
            led_d = bus.data;
        end
    end

    // Registered read data and LED register
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_dmem_q <= '0;
            led_q    <= '0;
        end else begin
            q_dmem_q <= q_dmem_d;
            led_q    <= led_d;
        end
    end

    // Word RAM; contents survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= bus.data;
        end
    end

    dmem_responder_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clock   (clock),
        .flush   (!reset),
        .push    (fifo_push),
        .din     (bus.data[7:0]),
        .full    (fifo_full),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .ovf_clr (ovf_clr),
        .ovf     (fifo_ovf)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_dmem_responder;
    localparam int unsigned RAM_DEPTH  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [11:0] MMIO_BASE  = 12'hF00;
    localparam logic [11:0] A_CYC  = MMIO_BASE + 12'd0;
    localparam logic [11:0] A_LED  = MMIO_BASE + 12'd1;
    localparam logic [11:0] A_TX   = MMIO_BASE + 12'd2;
    localparam logic [11:0] A_STAT = MMIO_BASE + 12'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] led_out;

    dmem_responder_if bus ();

    dmem_responder #(
        .RAM_DEPTH  (RAM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clock   (clk),
        .reset   (rst_n),
        .bus     (bus),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_led;
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] exp_q;
    bit          exp_q_known;
    bit          m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, output bit known);
        int sz;
        known = 1'b1;
        sz = m_fifo.size();
        if (int'(a) < int'(RAM_DEPTH)) begin
            known = m_ram.exists(int'(a));
            return known ? m_ram[int'(a)] : 32'd0;
        end
        if (a == A_CYC) begin
`ifdef DMEM_RESPONDER_TIMER_EN
            return m_cyc;
`else
            return 32'd0;
`endif
        end
        if (a == A_LED) return m_led;
        if (a == A_STAT) begin
            return 32'(sz * 256 + (m_ovf ? 4 : 0) + (sz == int'(FIFO_DEPTH) ? 2 : 0)
                       + (sz == 0 ? 1 : 0));
        end
        return 32'd0;
    endfunction

    // Model: advance one clock using the inputs presented this cycle
    always @(posedge clk) begin
        logic [31:0] rd;
        bit known, popped, was_full, push, clr;
        logic [11:0] a;
        a = bus.address_dmem;
        if (!rst_n) begin
            m_led = '0;
            m_fifo.delete();
            m_ovf = 1'b0;
            m_cyc = '0;
            exp_q = '0;
            exp_q_known = 1'b1;
            m_live = 1'b1;
        end else if (m_live) begin
            rd = model_read(a, known);
            was_full = (m_fifo.size() == int'(FIFO_DEPTH));
            popped = (m_fifo.size() > 0) && bus.tx_ready;
            push = 1'b0;
            clr = 1'b0;
            if (bus.wren) begin
                if (int'(a) < int'(RAM_DEPTH)) m_ram[int'(a)] = bus.data;
                else if (a == A_LED) m_led = bus.data;
                else if (a == A_TX) push = 1'b1;
                else if (a == A_STAT) clr = bus.data[2];
            end
            if (popped) void'(m_fifo.pop_front());
            if (push) begin
                if (was_full && !popped) m_ovf = 1'b1;
                else m_fifo.push_back(bus.data[7:0]);
            end
            if (clr) m_ovf = 1'b0;
            m_cyc = m_cyc + 32'd1;
            exp_q = rd;
            exp_q_known = known;
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (m_live) begin
            if (exp_q_known) chk("q_dmem", bus.q_dmem, exp_q);
            chk("tx_valid", {31'd0, bus.tx_valid}, {31'd0, m_fifo.size() > 0});
            if (m_fifo.size() > 0) chk("tx_data", {24'd0, bus.tx_data}, {24'd0, m_fifo[0]});
            chk("led_out", led_out, m_led);
        end
    end

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w,
                         input logic r);
        @(negedge clk);
        bus.address_dmem = a;
        bus.data = d;
        bus.wren = w;
        bus.tx_ready = r;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rand_addr();
        int unsigned p;
        p = $urandom_range(0, 9);
        case (p)
            0, 1, 2, 3, 4: return 12'($urandom_range(0, 7));
            5: return 12'(RAM_DEPTH - 1);
            6: return 12'(RAM_DEPTH + $urandom_range(0, 2));
            7: return ($urandom_range(0, 1) == 0) ? 12'hEFF : 12'(12'hF04 + $urandom_range(0, 3));
            default: return 12'(MMIO_BASE + 12'($urandom_range(0, 3)));
        endcase
    endfunction

    initial begin
        logic [31:0] v1, v2;
        bus.address_dmem = '0;
        bus.data = '0;
        bus.wren = 1'b0;
        bus.tx_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q", bus.q_dmem, 32'd0);
        chk("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_led", led_out, 32'd0);
        rst_n = 1'b1;

        // RAM: read-before-write then load of the new value
        drive(12'd5, 32'h1111_1111, 1'b1, 1'b0);
        drive(12'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        after_edge();
        chk("ram_old", bus.q_dmem, 32'h1111_1111);
        drive(12'd5, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("ram_new", bus.q_dmem, 32'hDEAD_BEEF);

        // Unmapped region
        drive(12'(RAM_DEPTH), 32'h1234_5678, 1'b1, 1'b0);
        drive(12'(RAM_DEPTH), 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("unmapped", bus.q_dmem, 32'd0);
        drive(12'hF07, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("unmapped_f07", bus.q_dmem, 32'd0);

        // LED write/read
        drive(A_LED, 32'hA5A5_0F0F, 1'b1, 1'b0);
        drive(A_LED, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("led_rd", bus.q_dmem, 32'hA5A5_0F0F);

        // Fill and overflow
        for (int i = 0; i < 9; i++) drive(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0);
        drive(A_STAT, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("stat_ovf", bus.q_dmem, 32'h0000_0806);
        drive(A_STAT, 32'h4, 1'b1, 1'b0);
        drive(A_STAT, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("stat_clr", bus.q_dmem, 32'h0000_0802);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            drive(12'd5, 32'd0, 1'b0, 1'b1);
            chk("drain", {24'd0, bus.tx_data}, 32'h41 + 32'(i));
        end
        drive(A_STAT, 32'd0, 1'b0, 1'b1);
        after_edge();
        chk("stat_empty", bus.q_dmem, 32'h0000_0001);
        chk("drained_valid", {31'd0, bus.tx_valid}, 32'd0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) drive(A_TX, 32'h50 + 32'(i), 1'b1, 1'b0);
        drive(A_TX, 32'h58, 1'b1, 1'b1);
        drive(A_STAT, 32'd0, 1'b0, 1'b0);
        after_edge();
        chk("stat_full_pp", bus.q_dmem, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            drive(12'd5, 32'd0, 1'b0, 1'b1);
            chk("pp_drain", {24'd0, bus.tx_data}, 32'h51 + 32'(i));
        end

        // Cycle counter
`ifdef DMEM_RESPONDER_TIMER_EN
        drive(A_CYC, 32'd0, 1'b0, 1'b0);
        after_edge();
        v1 = bus.q_dmem;
        for (int i = 0; i < 9; i++) drive(12'd5, 32'd0, 1'b0, 1'b0);
        drive(A_CYC, 32'd0, 1'b0, 1'b0);
        after_edge();
        v2 = bus.q_dmem;
        chk("cyc_delta", v2 - v1, 32'd10);
`else
        drive(A_CYC, 32'hFFFF_FFFF, 1'b1, 1'b0);
        after_edge();
        v1 = bus.q_dmem;
        chk("cyc_off", v1, 32'd0);
`endif

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) drive(A_TX, 32'h60 + 32'(i), 1'b1, 1'b0);
        drive(A_CYC, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.wren = 1'b0;
        rst_n = 1'b0;
        after_edge();
        chk("rst_mid_valid", {31'd0, bus.tx_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.address_dmem = A_CYC;
        after_edge();
        chk("rst_mid_cyc", bus.q_dmem, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                bus.wren = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                drive(rand_addr(), $urandom(), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) < 3));
            end
        end
        drive(12'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
